framebuffer_banked: RTL
=======================

# framebuffer_banked

Parametrised, single-clock dual-port framebuffer built from BANK_COUNT instances of the 1024×16 two-port SRAM macro.
- Port A serves the drawing/CPU side; port B serves the display scan-out side.
- Adds a registered read-bank mux, read-valid strobes, out-of-range detection, write-collision arbitration, and a hardware clear engine that fills the whole buffer with one colour over port A.

## Interface
- BANK_COUNT, 4: number of 1024×16 macros; DEPTH = BANK_COUNT×1024 words.
- ADDR_WIDTH, 17: address port width; must satisfy 2^ADDR_WIDTH ≥ DEPTH.
- clk  in  1  single clock for both ports and all macros.
- reset  in  1  synchronous, active-high.
- dataInA  in  16  port A write data.
- addressA  in  ADDR_WIDTH  port A word address.
- writeEnableA  in  1  port A write request.
- readEnableA  in  1  port A read request; ignored if writeEnableA is high.
- readyA  out  1  port A accepts requests this cycle.
- dataOutA  out  16  port A read data.
- validA  out  1  dataOutA updated this cycle.
- rangeErrA  out  1  one-cycle pulse: an accepted port A access had addressA ≥ DEPTH.
- dataInB, addressB, writeEnableB, readEnableB, dataOutB, validB, rangeErrB: same as port A, for port B. Port B has no ready; it is always accepted.
- clearStart  in  1  pulse: start a fill.
- clearColor  in  16  fill value, sampled on an accepted clearStart.
- clearBusy  out  1  fill in progress.
- clearDone  out  1  one-cycle pulse after the last fill write.

## Operation
- Address decode: bank = address[ADDR_WIDTH-1:10], offset = address[9:0].
  - A bank is enabled only if bank < BANK_COUNT.
  - Out-of-range writes are dropped; out-of-range reads return 16'h0000 and still assert valid.
- Each accepted read registers its bank index. On the next cycle, dataOut is taken from that bank's DOUT.
- dataOut holds its last value between reads.
- Collision handling:
  - A and B write the same in-range address in the same cycle: A wins and B's write is suppressed.
  - Read and write of the same address on opposite ports in the same cycle: read data is undefined (macro behaviour); valid still asserts.
- Clear FSM:
  - IDLE: readyA=1. clearStart → latch clearColor, counter=0, go to CLEAR.
  - CLEAR: readyA=0, clearBusy=1. Each cycle, port A writes the latched colour at counter, then counter+1.
    - On counter=DEPTH-1, write, then go to DONE.
    - User port A requests in CLEAR are ignored: no write, no valid, no rangeErr.
    - Port B operates normally, and its writes are suppressed at the address currently being cleared.
  - DONE: clearDone=1 for one cycle, then IDLE. readyA returns to 1 the same cycle the FSM enters IDLE.
- clearStart while clearBusy or in DONE is ignored.
- Counter width is ceil(log2(DEPTH)) and never wraps past DEPTH-1.
- Macro tie-offs: MEN=1, DLY=1, BM all ones, all BIST inputs 0.

## Timing
- Reset values: dataOutA=dataOutB=0, validA=validB=0, rangeErrA=rangeErrB=0, clearBusy=0, clearDone=0, FSM=IDLE, counter=0. readyA=0 while reset is high and 1 on the first cycle after.
- Read latency is one cycle: request at edge n, then dataOut and valid are present after edge n+1. Back-to-back reads sustain 1 word/cycle per port.
- Write is single-cycle; a read of the same address on the next cycle returns the new data.
- rangeErr pulses in the cycle after the offending request, aligned with valid for reads.
- A fill takes exactly DEPTH cycles of clearBusy, followed by one cycle of clearDone.
- Reset asserted mid-fill: return to IDLE next edge with outputs at reset values. Memory contents are then partially cleared and unspecified.
- Any read pending when reset hits produces no valid.

## Structure
- Shared package framebuffer_pkg holds:
  - BANK_WORDS=1024 and BANK_ADDR_BITS=10.
  - The clear FSM state enum (IDLE, CLEAR, DONE).
- Sub-module framebuffer_bank wraps one RM_IHPSG13_2P_1024x16_c2_bm_bist with all tie-offs. It exposes only enable, write, address, data-in and data-out per port.
- The top instantiates BANK_COUNT framebuffer_bank instances with explicit unique instance names.

## Test plan
- BANK_COUNT=4: write 16'hA5A5 at A addr 0x0C05, read via B at 0x0C05 → validB at +1 cycle, dataOutB=16'hA5A5; bank 0 offset 5 is unchanged.
- Stream A reads of 0x03FF, 0x0400, 0x0BFF on consecutive cycles, holding prefilled unique values → three consecutive valid cycles with correct values across the bank boundaries.
- A write 0x1000 (out of range, DEPTH=4096) → rangeErrA pulse, no bank written. B read 0x1FFFF → dataOutB=0, validB=1, rangeErrB=1.
- Same-cycle write to 0x0010: A=16'h1111, B=16'h2222 → subsequent read returns 16'h1111.
- clearStart with clearColor=16'h07E0 → clearBusy for exactly 4096 cycles, then clearDone for 1 cycle. readyA=0 throughout, and a sample of 64 random addresses reads 16'h07E0. A user write issued mid-fill has no effect.
- Assert reset at fill cycle 100 → next cycle clearBusy=0 and readyA=1 (once reset deasserts). A new clearStart then completes a full DEPTH-cycle fill.

Source files
------------

// File: rtl/framebuffer_pkg.sv
// Shared constants and clear-engine state type for the banked framebuffer.
package framebuffer_pkg;
  localparam int unsigned BANK_WORDS     = 1024;
  localparam int unsigned BANK_ADDR_BITS = 10;
  localparam int unsigned DATA_W         = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clear_state_e;
endpackage

// File: rtl/RM_IHPSG13_2P_1024x16_c2_bm_bist.sv
// Behavioural simulation model of the 1024x16 two-port SRAM macro (registered DOUT, bit mask).
module RM_IHPSG13_2P_1024x16_c2_bm_bist (
  input  logic        A_CLK,
  input  logic        A_MEN,
  input  logic        A_WEN,
  input  logic        A_REN,
  input  logic [9:0]  A_ADDR,
  input  logic [15:0] A_DIN,
  input  logic        A_DLY,
  output logic [15:0] A_DOUT,
  input  logic [15:0] A_BM,
  input  logic        A_BIST_CLK,
  input  logic        A_BIST_EN,
  input  logic        A_BIST_MEN,
  input  logic        A_BIST_WEN,
  input  logic        A_BIST_REN,
  input  logic [9:0]  A_BIST_ADDR,
  input  logic [15:0] A_BIST_DIN,
  input  logic [15:0] A_BIST_BM,
  input  logic        B_CLK,
  input  logic        B_MEN,
  input  logic        B_WEN,
  input  logic        B_REN,
  input  logic [9:0]  B_ADDR,
  input  logic [15:0] B_DIN,
  input  logic        B_DLY,
  output logic [15:0] B_DOUT,
  input  logic [15:0] B_BM,
  input  logic        B_BIST_CLK,
  input  logic        B_BIST_EN,
  input  logic        B_BIST_MEN,
  input  logic        B_BIST_WEN,
  input  logic        B_BIST_REN,
  input  logic [9:0]  B_BIST_ADDR,
  input  logic [15:0] B_BIST_DIN,
  input  logic [15:0] B_BIST_BM
);
  logic [15:0] mem [1024];
  logic        unused_ok;

  assign unused_ok = ^{A_DLY, A_BIST_CLK, A_BIST_EN, A_BIST_MEN, A_BIST_WEN, A_BIST_REN,
                       A_BIST_ADDR, A_BIST_DIN, A_BIST_BM, B_DLY, B_BIST_CLK, B_BIST_EN,
                       B_BIST_MEN, B_BIST_WEN, B_BIST_REN, B_BIST_ADDR, B_BIST_DIN, B_BIST_BM};

  // Array writes from both ports (A applied last on a same-word clash) and port A read.
  always_ff @(posedge A_CLK) begin
    if (B_MEN && B_WEN) mem[B_ADDR] <= (mem[B_ADDR] & ~B_BM) | (B_DIN & B_BM);
    if (A_MEN && A_WEN) mem[A_ADDR] <= (mem[A_ADDR] & ~A_BM) | (A_DIN & A_BM);
    if (A_MEN && A_REN) A_DOUT <= mem[A_ADDR];
  end

  // Port B read.
  always_ff @(posedge B_CLK) begin
    if (B_MEN && B_REN) B_DOUT <= mem[B_ADDR];
  end
endmodule

// File: rtl/framebuffer_bank.sv
// One framebuffer bank: the 2P SRAM macro with its static tie-offs applied.
module framebuffer_bank
  import framebuffer_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      a_en_i,
  input  logic                      a_we_i,
  input  logic [BANK_ADDR_BITS-1:0] a_addr_i,
  input  logic [DATA_W-1:0]         a_din_i,
  output logic [DATA_W-1:0]         a_dout_o,
  input  logic                      b_en_i,
  input  logic                      b_we_i,
  input  logic [BANK_ADDR_BITS-1:0] b_addr_i,
  input  logic [DATA_W-1:0]         b_din_i,
  output logic [DATA_W-1:0]         b_dout_o
);
  RM_IHPSG13_2P_1024x16_c2_bm_bist u_sram (
    .A_CLK(clk_i), .A_MEN(1'b1), .A_WEN(a_en_i & a_we_i), .A_REN(a_en_i & ~a_we_i),
    .A_ADDR(a_addr_i), .A_DIN(a_din_i), .A_DLY(1'b1), .A_DOUT(a_dout_o), .A_BM({DATA_W{1'b1}}),
    .A_BIST_CLK(1'b0), .A_BIST_EN(1'b0), .A_BIST_MEN(1'b0), .A_BIST_WEN(1'b0),
    .A_BIST_REN(1'b0), .A_BIST_ADDR(10'd0), .A_BIST_DIN(16'd0), .A_BIST_BM(16'd0),
    .B_CLK(clk_i), .B_MEN(1'b1), .B_WEN(b_en_i & b_we_i), .B_REN(b_en_i & ~b_we_i),
    .B_ADDR(b_addr_i), .B_DIN(b_din_i), .B_DLY(1'b1), .B_DOUT(b_dout_o), .B_BM({DATA_W{1'b1}}),
    .B_BIST_CLK(1'b0), .B_BIST_EN(1'b0), .B_BIST_MEN(1'b0), .B_BIST_WEN(1'b0),
    .B_BIST_REN(1'b0), .B_BIST_ADDR(10'd0), .B_BIST_DIN(16'd0), .B_BIST_BM(16'd0)
  );
endmodule

// File: rtl/framebuffer_banked.sv
// Dual-port banked framebuffer with registered read mux, range checks, collision
// arbitration and a port-A fill engine.
module framebuffer_banked
  import framebuffer_pkg::*;
#(
  parameter int unsigned BANK_COUNT = 4,
  parameter int unsigned ADDR_WIDTH = 17
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [DATA_W-1:0]     dataInA_i,
  input  logic [ADDR_WIDTH-1:0] addressA_i,
  input  logic                  writeEnableA_i,
  input  logic                  readEnableA_i,
  output logic                  readyA_o,
  output logic [DATA_W-1:0]     dataOutA_o,
  output logic                  validA_o,
  output logic                  rangeErrA_o,
  input  logic [DATA_W-1:0]     dataInB_i,
  input  logic [ADDR_WIDTH-1:0] addressB_i,
  input  logic                  writeEnableB_i,
  input  logic                  readEnableB_i,
  output logic [DATA_W-1:0]     dataOutB_o,
  output logic                  validB_o,
  output logic                  rangeErrB_o,
  input  logic                  clearStart_i,
  input  logic [DATA_W-1:0]     clearColor_i,
  output logic                  clearBusy_o,
  output logic                  clearDone_o
);
  localparam int unsigned DEPTH = BANK_COUNT * BANK_WORDS;
  localparam int unsigned CNT_W = $clog2(DEPTH);
  localparam int unsigned SEL_W = ADDR_WIDTH - BANK_ADDR_BITS;
  localparam int unsigned AW1   = ADDR_WIDTH + 1;

  clear_state_e          state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_W-1:0]     color_q, color_d;
  logic                  ready_q, ready_d, busy_q, busy_d, done_q, done_d;

  logic                  a_we, a_re, a_in, a_req, b_we, b_re, b_in, b_req;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_W-1:0]     a_din;
  logic [SEL_W-1:0]      a_sel, b_sel;
  logic [DATA_W-1:0]     dout_a [BANK_COUNT];
  logic [DATA_W-1:0]     dout_b [BANK_COUNT];
  logic [DATA_W-1:0]     mux_a, mux_b;

  logic                  rd_pend_a_q, rd_oor_a_q, err1_a_q, rd_pend_b_q, rd_oor_b_q, err1_b_q;
  logic [SEL_W-1:0]      rd_sel_a_q, rd_sel_b_q;
  logic [DATA_W-1:0]     dout_a_q, dout_b_q;
  logic                  valid_a_q, valid_b_q, err_a_q, err_b_q;

  // Clear FSM state and fill datapath registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      color_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      color_q <= color_d;
    end
  end

  // Next state and fill counter; the counter saturates at the last word.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    color_d = color_q;
    case (state_q)
      IDLE: begin
        if (clearStart_i) begin
          state_d = CLEAR;
          cnt_d   = '0;
          color_d = clearColor_i;
        end
      end
      CLEAR: begin
        if (cnt_q == CNT_W'(DEPTH - 1)) state_d = DONE;
        else                            cnt_d   = cnt_q + CNT_W'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status flags and port A source select (fill engine owns port A while clearing).
  always_comb begin
    ready_d = (state_d == IDLE);
    busy_d  = (state_d == CLEAR);
    done_d  = (state_d == DONE);
    a_we    = 1'b0;
    a_re    = 1'b0;
    a_addr  = addressA_i;
    a_din   = dataInA_i;
    if (state_q == CLEAR) begin
      a_we   = 1'b1;
      a_addr = ADDR_WIDTH'(cnt_q);
      a_din  = color_q;
    end else if (ready_q) begin
      a_we = writeEnableA_i;
      a_re = readEnableA_i & ~writeEnableA_i;
    end
  end

  // Registered status flags.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign a_in  = ({1'b0, a_addr} < AW1'(DEPTH));
  assign b_in  = ({1'b0, addressB_i} < AW1'(DEPTH));
  assign a_req = (a_we | a_re) & ~reset_i;
  assign b_we  = writeEnableB_i & ~(a_we & a_in & (a_addr == addressB_i));
  assign b_re  = readEnableB_i & ~writeEnableB_i;
  assign b_req = (b_we | b_re) & ~reset_i;
  assign a_sel = a_addr[ADDR_WIDTH-1:BANK_ADDR_BITS];
  assign b_sel = addressB_i[ADDR_WIDTH-1:BANK_ADDR_BITS];

  for (genvar g = 0; g < BANK_COUNT; g++) begin : g_bank
    framebuffer_bank u_bank (
      .clk_i   (clk_i),
      .a_en_i  (a_req & a_in & (a_sel == SEL_W'(g))),
      .a_we_i  (a_we),
      .a_addr_i(a_addr[BANK_ADDR_BITS-1:0]),
      .a_din_i (a_din),
      .a_dout_o(dout_a[g]),
      .b_en_i  (b_req & b_in & (b_sel == SEL_W'(g))),
      .b_we_i  (b_we),
      .b_addr_i(addressB_i[BANK_ADDR_BITS-1:0]),
      .b_din_i (dataInB_i),
      .b_dout_o(dout_b[g])
    );
  end

  // Select the DOUT of the bank each pending read addressed.
  always_comb begin
    mux_a = '0;
    mux_b = '0;
    for (int unsigned b = 0; b < BANK_COUNT; b++) begin
      if (rd_sel_a_q == SEL_W'(b)) mux_a = dout_a[b];
      if (rd_sel_b_q == SEL_W'(b)) mux_b = dout_b[b];
    end
  end

  // Read/error pipeline: request stage then output stage, holding data between reads.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_pend_a_q <= 1'b0; rd_oor_a_q <= 1'b0; err1_a_q <= 1'b0; rd_sel_a_q <= '0;
      rd_pend_b_q <= 1'b0; rd_oor_b_q <= 1'b0; err1_b_q <= 1'b0; rd_sel_b_q <= '0;
      dout_a_q    <= '0;   valid_a_q  <= 1'b0; err_a_q  <= 1'b0;
      dout_b_q    <= '0;   valid_b_q  <= 1'b0; err_b_q  <= 1'b0;
    end else begin
      rd_pend_a_q <= a_re;  rd_oor_a_q <= ~a_in; err1_a_q <= a_req & ~a_in; rd_sel_a_q <= a_sel;
      rd_pend_b_q <= b_re;  rd_oor_b_q <= ~b_in; err1_b_q <= (writeEnableB_i | b_re) & ~b_in;
      rd_sel_b_q  <= b_sel;
      valid_a_q   <= rd_pend_a_q;
      err_a_q     <= err1_a_q;
      valid_b_q   <= rd_pend_b_q;
      err_b_q     <= err1_b_q;
      if (rd_pend_a_q) dout_a_q <= rd_oor_a_q ? '0 : mux_a;
      if (rd_pend_b_q) dout_b_q <= rd_oor_b_q ? '0 : mux_b;
    end
  end

  assign readyA_o    = ready_q;
  assign clearBusy_o = busy_q;
  assign clearDone_o = done_q;
  assign dataOutA_o  = dout_a_q;
  assign validA_o    = valid_a_q;
  assign rangeErrA_o = err_a_q;
  assign dataOutB_o  = dout_b_q;
  assign validB_o    = valid_b_q;
  assign rangeErrB_o = err_b_q;
endmodule
